// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared definitions for the DMEM load/store unit.
//   - RV32I load/store width codes (funct3)
//   - FSM state encoding
//   - alignment / legality helpers used at request accept
package dmem_lsu_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsuStateT;

  // Halfwords must sit on even bytes, words on multiples of four.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      FUNCT3_H, FUNCT3_HU: mis = addrLo[0];
      FUNCT3_W:            mis = (addrLo != 2'b00);
      default:             mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Reserved width codes, and unsigned widths which have no store form.
  function automatic logic isIllegal(input logic we, input logic [2:0] funct3);
    logic bad;
    bad = 1'b0;
    case (funct3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      FUNCT3_BU, FUNCT3_HU:   bad = we;
      default:                bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: groups the core-side request/response handshake and the
// DMEM word port of the load/store unit.
//   slave  modport : the LSU view (accepts requests, drives DMEM)
//   master modport : the environment view (core + DMEM)
interface dmem_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_dataW;
  logic              dmem_MemRW;
  logic [DATA_W-1:0] dmem_dataR;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_dataR,
    output req_ready, resp_valid, resp_rdata, resp_err,
           dmem_addr, dmem_dataW, dmem_MemRW
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_dataR,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           dmem_addr, dmem_dataW, dmem_MemRW
  );
endinterface

// File: rtl/dmem_lsu_lane.sv
// dmem_lsu_lane: combinational byte-lane logic of the load/store unit.
//   rword      in  : word read from DMEM
//   wdata      in  : store data, LSB-justified
//   funct3     in  : RV32I width code
//   byteOff    in  : addr[1:0] of the request
//   loadData   out : selected lane, sign/zero-extended (word passes through)
//   mergedWord out : rword with the addressed lane replaced by wdata (SW: wdata)
module dmem_lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byteOff,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    byteSel    = rword[{byteOff, 3'b000} +: 8];
    halfSel    = byteOff[1] ? rword[31:16] : rword[15:0];
    loadData   = rword;
    mergedWord = wdata;

    case (funct3)
      FUNCT3_B:  loadData = {{24{byteSel[7]}}, byteSel};
      FUNCT3_BU: loadData = {24'd0, byteSel};
      FUNCT3_H:  loadData = {{16{halfSel[15]}}, halfSel};
      FUNCT3_HU: loadData = {16'd0, halfSel};
      default:   loadData = rword;
    endcase

    case (funct3)
      FUNCT3_B, FUNCT3_BU: begin
        mergedWord = rword;
        mergedWord[{byteOff, 3'b000} +: 8] = wdata[7:0];
      end
      FUNCT3_H, FUNCT3_HU: begin
        mergedWord = rword;
        mergedWord[{byteOff[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: mergedWord = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit turning one core request into DMEM word accesses.
// Sub-word stores are read-modify-write (RD then WR).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dmem_lsu_if.slave (request/response handshake + DMEM port)
// Build option: define DMEM_LSU_ERR_EN to enable misalignment / illegal
// funct3 detection and resp_err. Without it, low address bits are ignored
// for alignment and illegal width codes behave as W.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_lsu_if.slave   bus
);

  lsuStateT          state;
  logic              weQ;
  logic [2:0]        funct3Q;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] rwordQ;
  logic              errQ;
  logic              readyQ;
  logic              respValidQ;
  logic              memRwQ;
  logic [ADDR_W-1:0] dmemAddrQ;

  logic              acceptErr;
  logic [2:0]        funct3N;
  logic [ADDR_W-1:0] alignedAddr;
  logic [31:0]       loadData;
  logic [31:0]       mergedWord;

  assign alignedAddr = {bus.req_addr[ADDR_W-1:2], 2'b00};

`ifdef DMEM_LSU_ERR_EN
  assign acceptErr = isIllegal(bus.req_we, bus.req_funct3) |
                     is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign funct3N   = bus.req_funct3;
`else
  assign acceptErr = 1'b0;
  assign funct3N   = isIllegal(bus.req_we, bus.req_funct3) ? FUNCT3_W : bus.req_funct3;
`endif

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // sampled synchronously, so it takes effect at the next clk edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      weQ        <= 1'b0;
      funct3Q    <= FUNCT3_W;
      addrQ      <= '0;
      wdataQ     <= '0;
      rwordQ     <= '0;
      errQ       <= 1'b0;
      readyQ     <= 1'b1;
      respValidQ <= 1'b0;
      memRwQ     <= 1'b0;
      dmemAddrQ  <= '0;
    end else begin
      // One-cycle flags default low; each transition raises its own.
      readyQ     <= 1'b0;
      respValidQ <= 1'b0;
      memRwQ     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            weQ     <= bus.req_we;
            funct3Q <= funct3N;
            addrQ   <= bus.req_addr;
            wdataQ  <= bus.req_wdata;
            errQ    <= acceptErr;
            if (acceptErr) begin
              state      <= RESP;
              respValidQ <= 1'b1;
            end else if (bus.req_we && funct3N == FUNCT3_W) begin
              state     <= WR;
              memRwQ    <= 1'b1;
              dmemAddrQ <= alignedAddr;
            end else begin
              state     <= RD;
              dmemAddrQ <= alignedAddr;
            end
          end else begin
            readyQ <= 1'b1;
          end
        end
        RD: begin
          rwordQ <= bus.dmem_dataR;
          if (weQ) begin
            state  <= WR;
            memRwQ <= 1'b1;
          end else begin
            state      <= RESP;
            respValidQ <= 1'b1;
          end
        end
        WR: begin
          state      <= RESP;
          respValidQ <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          readyQ <= 1'b1;
        end
      endcase
    end
  end

  dmem_lsu_lane uLane (
    .rword      (rwordQ),
    .wdata      (wdataQ),
    .funct3     (funct3Q),
    .byteOff    (addrQ[1:0]),
    .loadData   (loadData),
    .mergedWord (mergedWord)
  );

  assign bus.req_ready  = readyQ;
  assign bus.resp_valid = respValidQ;
  assign bus.resp_rdata = (respValidQ && !weQ && !errQ) ? loadData : '0;
  assign bus.dmem_addr  = dmemAddrQ;
  assign bus.dmem_MemRW = memRwQ;
  assign bus.dmem_dataW = (state == WR) ? mergedWord : '0;
`ifdef DMEM_LSU_ERR_EN
  assign bus.resp_err   = respValidQ & errQ;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule
